// File: rtl/uart_core.sv
// UART engine: baud tick generator, TX FSM, 16x-oversampled RX FSM and a
// show-ahead RX FIFO with overrun reporting. Single clock, sync active-low reset.
//   clk, reset_n           : clock / reset
//   divisor, cfg_*         : baud divisor and frame format
//   tx_data/valid/ready, tx: transmit byte stream and serial out
//   rx, rx_data/flags/valid/ready, rx_overrun, rx_count: receive path
module uart_core #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DIV_W-1:0]              divisor,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [7:0] len_mask(input logic [1:0] l);
    unique case (l)
      2'b00:   return 8'h1F;
      2'b01:   return 8'h3F;
      2'b10:   return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic par_en(input logic [1:0] p);
    return p == 2'b01 || p == 2'b10;
  endfunction

  // ---------------- tick generator ----------------
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             tx_hs;

  assign tick = (div_q == divisor);

  // Restarting on a TX handshake gives every TX bit a full 16 ticks.
  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
    if (tx_hs) div_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= div_d;
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_state_e;

  tx_state_e  tst_q, tst_d;
  logic [7:0] tdat_q, tdat_d;
  logic [2:0] tnb_q, tnb_d;
  logic [4:0] ttk_q, ttk_d;
  logic [1:0] tlen_q, tlen_d;
  logic [1:0] tpar_q, tpar_d;
  logic       tstp_q, tstp_d;
  logic       tline;

  assign tx_ready = reset_n && (tst_q == TX_IDLE);
  assign tx_hs    = tx_valid && tx_ready;
  assign tx       = !reset_n || tline;

  always_comb begin
    tst_d  = tst_q;
    tdat_d = tdat_q;
    tnb_d  = tnb_q;
    ttk_d  = ttk_q;
    tlen_d = tlen_q;
    tpar_d = tpar_q;
    tstp_d = tstp_q;
    tline  = 1'b1;
    unique case (tst_q)
      TX_IDLE: begin
        if (tx_hs) begin
          tst_d  = TX_START;
          tdat_d = tx_data & len_mask(cfg_data_bits);
          tlen_d = cfg_data_bits;
          tpar_d = cfg_parity;
          tstp_d = cfg_stop2;
          ttk_d  = '0;
        end
      end
      TX_START: begin
        tline = 1'b0;
        if (tick) begin
          ttk_d = ttk_q + 5'd1;
          if (ttk_q == 5'd15) begin
            ttk_d = '0;
            tnb_d = '0;
            tst_d = TX_DATA;
          end
        end
      end
      TX_DATA: begin
        tline = tdat_q[tnb_q];
        if (tick) begin
          ttk_d = ttk_q + 5'd1;
          if (ttk_q == 5'd15) begin
            ttk_d = '0;
            tnb_d = tnb_q + 3'd1;
            if (tnb_q == {1'b0, tlen_q} + 3'd4)
              tst_d = par_en(tpar_q) ? TX_PAR : TX_STOP;
          end
        end
      end
      TX_PAR: begin
        // Data is pre-masked, so the reduction covers only the word.
        tline = (^tdat_q) ^ (tpar_q == 2'b01);
        if (tick) begin
          ttk_d = ttk_q + 5'd1;
          if (ttk_q == 5'd15) begin
            ttk_d = '0;
            tst_d = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          ttk_d = ttk_q + 5'd1;
          if (ttk_q == (tstp_q ? 5'd31 : 5'd15)) begin
            ttk_d = '0;
            tst_d = TX_IDLE;
          end
        end
      end
      default: tst_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tst_q  <= TX_IDLE;
      tdat_q <= '0;
      tnb_q  <= '0;
      ttk_q  <= '0;
      tlen_q <= '0;
      tpar_q <= '0;
      tstp_q <= 1'b0;
    end else begin
      tst_q  <= tst_d;
      tdat_q <= tdat_d;
      tnb_q  <= tnb_d;
      ttk_q  <= ttk_d;
      tlen_q <= tlen_d;
      tpar_q <= tpar_d;
      tstp_q <= tstp_d;
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
  } rx_state_e;

  logic       sync1_q, rxs_q;
  rx_state_e  rst_q, rst_d;
  logic [3:0] rph_q, rph_d;
  logic [2:0] rnb_q, rnb_d;
  logic [7:0] rdat_q, rdat_d;
  logic [1:0] rlen_q, rlen_d;
  logic [1:0] rpar_q, rpar_d;
  logic       rperr_q, rperr_d;
  logic       push_q, push_d;
  logic [9:0] pdat_q, pdat_d;

  always_comb begin
    rst_d   = rst_q;
    rph_d   = rph_q;
    rnb_d   = rnb_q;
    rdat_d  = rdat_q;
    rlen_d  = rlen_q;
    rpar_d  = rpar_q;
    rperr_d = rperr_q;
    push_d  = 1'b0;
    pdat_d  = pdat_q;
    unique case (rst_q)
      RX_IDLE: begin
        if (!rxs_q) begin
          rst_d   = RX_START;
          rph_d   = '0;
          rdat_d  = '0;
          rperr_d = 1'b0;
          rlen_d  = cfg_data_bits;
          rpar_d  = cfg_parity;
        end
      end
      RX_START: begin
        if (tick) begin
          rph_d = rph_q + 4'd1;
          if (rph_q == 4'd7) begin
            rph_d = '0;
            rnb_d = '0;
            rst_d = rxs_q ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rph_d = rph_q + 4'd1;
          if (rph_q == 4'd15) begin
            rph_d         = '0;
            rdat_d[rnb_q] = rxs_q;
            rnb_d         = rnb_q + 3'd1;
            if (rnb_q == {1'b0, rlen_q} + 3'd4)
              rst_d = par_en(rpar_q) ? RX_PAR : RX_STOP;
          end
        end
      end
      RX_PAR: begin
        if (tick) begin
          rph_d = rph_q + 4'd1;
          if (rph_q == 4'd15) begin
            rph_d   = '0;
            rperr_d = (^rdat_q) ^ rxs_q ^ (rpar_q == 2'b01);
            rst_d   = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rph_d = rph_q + 4'd1;
          if (rph_q == 4'd15) begin
            rph_d  = '0;
            push_d = 1'b1;
            pdat_d = {!rxs_q, rperr_q, rdat_q};
            rst_d  = RX_IDLE;
          end
        end
      end
      default: rst_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      rst_q   <= RX_IDLE;
      rph_q   <= '0;
      rnb_q   <= '0;
      rdat_q  <= '0;
      rlen_q  <= '0;
      rpar_q  <= '0;
      rperr_q <= 1'b0;
      push_q  <= 1'b0;
      pdat_q  <= '0;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
      rst_q   <= rst_d;
      rph_q   <= rph_d;
      rnb_q   <= rnb_d;
      rdat_q  <= rdat_d;
      rlen_q  <= rlen_d;
      rpar_q  <= rpar_d;
      rperr_q <= rperr_d;
      push_q  <= push_d;
      pdat_q  <= pdat_d;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          empty, full, pop, wr;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop   = !empty && rx_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign wr    = push_q && (!full || pop);

  assign rx_valid      = reset_n && !empty;
  assign rx_overrun    = reset_n && push_q && full && !pop;
  assign rx_count      = reset_n ? cnt_q : '0;
  assign rx_data       = rx_valid ? mem_q[rp_q][7:0] : 8'h00;
  assign rx_parity_err = rx_valid && mem_q[rp_q][8];
  assign rx_frame_err  = rx_valid && mem_q[rp_q][9];

  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= pdat_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr)  wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      unique case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised UART core: one transmitter, one 16x-oversampled receiver and a receive FIFO, with runtime-selectable baud divisor, word length, parity and stop bits. It replaces the fixed-function UART top as the serial engine behind the bus-facing register block. All logic runs on one clock. The register block drives the configuration inputs and the ready/valid byte streams.

## Interface
Parameters:
- `DIV_W`, 16: width of the baud divisor.
- `FIFO_DEPTH`, 16: RX FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `reset_n`  in  1: reset, synchronous and active-low.
- `divisor`  in  DIV_W: clk cycles per 16x tick, minus 1.
- `cfg_data_bits`  in  2: 00=5, 01=6, 10=7, 11=8 data bits.
- `cfg_parity`  in  2: 00=none, 01=odd, 10=even, 11=none.
- `cfg_stop2`  in  1: 1 = two stop bits on TX; RX always checks only the first stop bit.
- `tx_data`  in  8: byte to send; bits above the word length are ignored.
- `tx_valid`  in  1: TX request.
- `tx_ready`  out  1: TX idle and able to accept.
- `tx`  out  1: serial output, idle high.
- `rx`  in  1: asynchronous serial input.
- `rx_data`  out  8: FIFO head; unused upper bits are 0.
- `rx_parity_err`  out  1: parity error flag of the FIFO head.
- `rx_frame_err`  out  1: stop-bit error flag of the FIFO head.
- `rx_valid`  out  1: FIFO not empty.
- `rx_ready`  in  1: pop the FIFO head.
- `rx_overrun`  out  1: one-cycle pulse when a received byte is dropped.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- **Tick generator**
  - Free-running counter runs 0..`divisor`.
  - `tick16` pulses for one cycle when the counter equals `divisor`, then the counter wraps to 0.
  - `divisor`=0 gives a tick every cycle.
- **Configuration latching**
  - TX latches the config inputs at the handshake.
  - RX latches them at start-bit detect.
  - Changes during a frame do not affect that frame.
- **TX FSM: IDLE → START → DATA → PARITY (skipped if none) → STOP → IDLE**
  - In IDLE, `tx_ready`=1. A handshake (`tx_valid & tx_ready`) latches the data and enters START.
  - Each bit lasts 16 ticks. Data is sent LSB first.
  - Odd parity makes the total count of 1s, data plus parity bit, odd; even parity makes it even.
  - STOP lasts 16 ticks, or 32 if `cfg_stop2`.
- **RX front end**
  - `rx` passes through a 2-flop synchroniser.
- **RX FSM: IDLE → START → DATA → PARITY → STOP → IDLE**
  - A synchronised low in IDLE enters START and clears the tick phase count.
  - At tick 8, if the line is high again, the start is false: return to IDLE with no byte.
  - Otherwise each later bit is sampled at its own mid-bit, every 16 ticks.
  - Parity error = sampled parity ≠ computed parity.
  - Frame error = sampled stop bit is 0.
  - After the stop sample, {frame_err, parity_err, data} is pushed and the FSM returns to IDLE. The line is not required to go high first; a low stop bit may begin the next start.
- **RX FIFO**
  - Show-ahead: `rx_data`, `rx_parity_err` and `rx_frame_err` reflect the head whenever `rx_valid`=1.
  - A pop occurs on `rx_valid & rx_ready`.
  - Full with no pop: an incoming byte is dropped, `rx_overrun` pulses, and the contents are unchanged.
  - Full with a pop in the same cycle: the push succeeds and there is no overrun.
  - Empty: `rx_ready` is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`. `rx_count` ranges 0..`FIFO_DEPTH`.

## Timing
- **Values while `reset_n`=0**
  - `tx`=1, `tx_ready`=0, `rx_valid`=0, `rx_overrun`=0, `rx_count`=0.
  - `rx_data`, `rx_parity_err` and `rx_frame_err` read 0.
  - Both FSMs are IDLE, the FIFO is flushed and the tick counter is 0.
- **First cycle after release:** `tx_ready`=1.
- **Reset mid-frame:** `tx` is high at the next edge and the partial RX byte is discarded.
- **TX**
  - Handshake at edge N: `tx_ready`=0 and `tx`=0 from edge N+1.
  - The tick counter restarts at the handshake, so each bit lasts exactly 16·(`divisor`+1) cycles.
  - `tx_ready` returns to 1 in the cycle after the last stop-bit tick.
  - Frame length: (1 + data bits + parity bit if enabled + 1 or 2 stop bits)·16·(`divisor`+1) cycles.
- **RX latency**
  - The FIFO write happens on the edge after the stop-bit sample tick; `rx_valid` is 1 in the following cycle.
  - `rx_overrun` asserts in the same cycle the write would have occurred.
- **Pop:** the head advances one cycle after the pop edge. `rx_count` updates on the same edge as a push or pop.

## Test plan
- **TX frame:** 8N1, `divisor`=0, send 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; `tx_ready` low for exactly 160 cycles.
- **Loopback, 7 data bits, even parity, 2 stop bits:** `tx`→`rx`, send 0x55 then 0x2A → `rx_data` 0x55 then 0x2A, both error flags 0, `rx_count` peaks at 2.
- **Parity error:** 8O1, drive a frame for 0x01 with parity bit 1 → `rx_data`=0x01, `rx_parity_err`=1, `rx_frame_err`=0.
- **Frame error:** 8N1, drive a frame for 0x3C with stop bit 0 → `rx_data`=0x3C, `rx_frame_err`=1.
- **Overrun:** `FIFO_DEPTH`=4, `rx_ready`=0, receive 0x10–0x14 → `rx_count`=4, exactly one `rx_overrun` pulse; then pop with `rx_ready`=1 → 0x10–0x13.
- **False start and reset:** an `rx` low pulse of 4 cycles at `divisor`=0 → no byte. Drop `reset_n` mid-TX → `tx`=1 the next cycle and `tx_ready`=1 one cycle after release.
